lfsr_check: RTL and testbench
=============================

LFSR_CHECK -- requirements
Module: lfsr_check

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DataBits, 8, data width; CountBits, 32, counter width; MaxLength, 1024, maximum and reset frame length; LfsrSeed, 17'h15555, LFSR seed; GoDefault, 0; RepeatDefault, 0; PatternDefault, 0.
REQ-002 The block SHALL have these ports (name, direction, width, meaning): clk, in, 1, the only clock; rst_n, in, 1, asynchronous active-low reset; cfg_paddr, in, 6, APB byte address; cfg_pwrite, in, 1; cfg_pwdata, in, 32; cfg_psel, in, 1; cfg_penable, in, 1; cfg_pready, out, 1; cfg_prdata, out, 32; cfg_pslverr, out, 1; din_valid, in, 1; din_ready, out, 1; din_data, in, DataBits; din_eof, in, 1, last word of frame.
REQ-003 APB word address = cfg_paddr>>2; registers: 0 Go RW, 1 RxCount RO, 2 Clr RW, 3 Repeat RW, 4 Length RW, 5 Pattern RW (0 LFSR, 1 counter, 2 ones, 3 zeros), 6 ErrCount RO, 7 FrameCount RO, 8 LenErrCount RO, 9 Status RO (bit0 checking, bit1 sticky error), 10-12 capture RO (REQ-022).

Function
REQ-004 Register access SHALL occur in the APB setup phase (psel & !penable); cfg_prdata registered, updated one clk later; unmapped reads leave cfg_prdata unchanged; cfg_pready=1 and cfg_pslverr=0 constant.
REQ-005 A beat SHALL be din_valid & din_ready; din_ready SHALL be 0 in reset and 1 from the first clk after reset release.
REQ-006 State machine states SHALL be Idle, Sync and Check.
REQ-007 Idle: beats are accepted and discarded, with no counter updates; when Go=1: Repeat=1 -> Sync, else -> Check with the expected generator at its initial value.
REQ-008 Sync: beats are discarded; a beat with din_eof -> Check; Go=0 -> Idle.
REQ-009 Check: each beat increments RxCount and compares din_data with the expected word; a mismatch increments ErrCount and sets sticky error.
REQ-010 Expected word SHALL be produced by lfsr17_shift (seed LfsrSeed, shift on each Check beat) for Pattern 0, a DataBits counter starting at 0 for Pattern 1, all ones for 2, and zero for 3.
REQ-011 On a Check beat with din_eof: FrameCount++; if Repeat=1, the LFSR is re-initialised to seed (init) and the counter is set to 0 for the next word; if Go=0, state -> Idle.
REQ-012 A word index SHALL count Check beats within a frame and clear after each eof beat; an eof beat with index != Length-1 SHALL increment LenErrCount.
REQ-013 All count registers SHALL saturate at all ones, never wrap; the word index SHALL wrap modulo 2^32.
REQ-014 Comparison and counter updates for a beat SHALL be visible in registers by the second clk after that beat.
REQ-015 While Clr=1: state forced to Idle, all counters, word index, sticky error and expected generator held at initial values; config registers unaffected.
REQ-016 Length SHALL not be below 2; Length, Pattern and Repeat SHALL only be changed while in Idle (otherwise results are unspecified).

Reset
REQ-017 rst_n low SHALL asynchronously set: state Idle, din_ready 0, cfg_prdata 0, all counters, sticky error and capture registers 0, Go=GoDefault, Repeat=RepeatDefault, Pattern=PatternDefault, Length=MaxLength, Clr=0.
REQ-018 Reset mid-frame SHALL discard the partial frame; after release, checking resumes per REQ-007.
REQ-019 Deassertion SHALL be synchronised to clk; lfsr17_shift rst SHALL be driven by !rst_n | Clr.

Configuration
REQ-020 Macro LFSR_CHECK_CAPTURE_EN SHALL control first-error capture.
REQ-021 With LFSR_CHECK_CAPTURE_EN defined: on the first mismatch since reset/Clr, the block SHALL record RxCount-before-increment (addr 10), the expected word (11) and the received word (12); later errors SHALL not overwrite.
REQ-022 Without LFSR_CHECK_CAPTURE_EN: addresses 10-12 SHALL read 0 and no capture logic SHALL exist.

Verification
REQ-023 Pattern 0, Repeat=0, Length=4, Go=1, 3 frames of correct LFSR data -> RxCount=12, FrameCount=3, ErrCount=0, LenErrCount=0.
REQ-024 Pattern 1, Repeat=1, Length=4, Go set mid-frame (words 2,3 eof) then frames 0..3 x2 -> Sync discards 2 words; RxCount=8, ErrCount=0.
REQ-025 Pattern 3, word 5 = 8'h01 with capture enabled -> ErrCount=1, Status=3, capture = 5 / 0 / 8'h01.
REQ-026 Length=4, a frame with eof on the 3rd word -> LenErrCount=1, next 4-word frame clean.
REQ-027 Pattern 2, CountBits=4, 20 beats of 8'h00 -> ErrCount=15 (saturated); then Clr=1,0 -> all counters 0, state Idle.
REQ-028 rst_n pulsed low mid-frame -> din_ready=0 and counters 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/lfsr_check_if.sv
// lfsr_check_if -- bus bundle for the lfsr_check pattern checker.
//
// Signals:
//   cfg_*  : APB slave port (6-bit byte address, 32-bit data). Accesses are
//            decoded in the setup phase; pready is tied high, pslverr low.
//   din_*  : streaming input (data word plus end-of-frame marker).
//
// Modports:
//   master : drives APB requests and the data stream (bench / upstream).
//   slave  : the checker itself.
//
// Handshake: a din beat transfers on every rising clk edge where din_valid
// and din_ready are both high. din_data and din_eof are only meaningful
// while din_valid is high. The producer must not drop din_valid or change
// din_data/din_eof until the beat has been taken. din_ready does not depend
// on din_valid.
interface lfsr_check_if #(
    parameter int DataBits = 8
);
    logic [5:0]          cfg_paddr;
    logic                cfg_pwrite;
    logic [31:0]         cfg_pwdata;
    logic                cfg_psel;
    logic                cfg_penable;
    logic                cfg_pready;
    logic [31:0]         cfg_prdata;
    logic                cfg_pslverr;
    logic                din_valid;
    logic                din_ready;
    logic [DataBits-1:0] din_data;
    logic                din_eof;

    modport master (
        output cfg_paddr, cfg_pwrite, cfg_pwdata, cfg_psel, cfg_penable,
        input  cfg_pready, cfg_prdata, cfg_pslverr,
        output din_valid, din_data, din_eof,
        input  din_ready
    );

    modport slave (
        input  cfg_paddr, cfg_pwrite, cfg_pwdata, cfg_psel, cfg_penable,
        output cfg_pready, cfg_prdata, cfg_pslverr,
        input  din_valid, din_data, din_eof,
        output din_ready
    );
endinterface

// File: rtl/lfsr_check.sv
// lfsr_check -- checks an incoming word stream against a known pattern
// (17-bit LFSR, incrementing counter, all ones or all zeros) and keeps
// word / error / frame / frame-length-error statistics readable over APB.
//
// Ports:
//   clk    : the only clock
//   rst_n  : asynchronous active-low reset; deassertion is synchronised
//   bus    : lfsr_check_if.slave (APB config port + din stream)
//
// Register map (word address = cfg_paddr >> 2):
//   0 Go RW, 1 RxCount RO, 2 Clr RW, 3 Repeat RW, 4 Length RW,
//   5 Pattern RW (0 LFSR, 1 counter, 2 ones, 3 zeros), 6 ErrCount RO,
//   7 FrameCount RO, 8 LenErrCount RO, 9 Status RO (bit0 checking,
//   bit1 sticky error), 10..12 first-error capture RO.
//
// Build option: define LFSR_CHECK_CAPTURE_EN to keep a copy of the first
// mismatch (RxCount before increment, expected word, received word) at
// addresses 10..12. Without it those addresses read as zero.

// Fibonacci LFSR, x^17 + x^14 + 1. rst and init both load the seed; rst is
// a synchronous clear driven by the checker's reset and Clr.
module lfsr17_shift #(
    parameter logic [16:0] Seed = 17'h15555
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        shift,
    output logic [16:0] state
);
    logic [16:0] state_q;
    logic [16:0] state_d;

    always_comb begin
        state_d = state_q;
        if (rst || init) begin
            state_d = Seed;
        end else if (shift) begin
            state_d = {state_q[15:0], state_q[16] ^ state_q[13]};
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    assign state = state_q;
endmodule

module lfsr_check #(
    parameter int          DataBits       = 8,
    parameter int          CountBits      = 32,
    parameter int          MaxLength      = 1024,
    parameter logic [16:0] LfsrSeed       = 17'h15555,
    parameter logic        GoDefault      = 1'b0,
    parameter logic        RepeatDefault  = 1'b0,
    parameter logic [1:0]  PatternDefault = 2'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    lfsr_check_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_CHECK} state_e;

    function automatic logic [CountBits-1:0] sat_inc(input logic [CountBits-1:0] v);
        if (&v) return v;
        return v + CountBits'(1);
    endfunction

    // Reset: asserts asynchronously, releases two clk edges after rst_n.
    logic rst_meta_q, rst_core_n_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q   <= 1'b0;
            rst_core_n_q <= 1'b0;
        end else begin
            rst_meta_q   <= 1'b1;
            rst_core_n_q <= rst_meta_q;
        end
    end

    // din_ready rises on the first edge after release. Beats taken before
    // the core leaves reset land in Idle and are discarded anyway.
    logic din_ready_q, din_ready_d;
    assign din_ready_d = 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_ready_q <= 1'b0;
        else        din_ready_q <= din_ready_d;
    end

    state_e                state_q, state_d;
    logic                  go_q, go_d, clr_q, clr_d, repeat_q, repeat_d;
    logic [1:0]            pattern_q, pattern_d;
    logic [31:0]           length_q, length_d, word_idx_q, word_idx_d;
    logic [CountBits-1:0]  rx_count_q, rx_count_d, err_count_q, err_count_d;
    logic [CountBits-1:0]  frame_count_q, frame_count_d, len_err_count_q, len_err_count_d;
    logic                  sticky_q, sticky_d;
    logic [DataBits-1:0]   cnt_q, cnt_d;
    logic [31:0]           prdata_q, prdata_d;

    logic                  beat, check_beat, checking, gen_init, mismatch;
    logic [DataBits-1:0]   exp_word;
    logic [16:0]           lfsr_state;
    logic [3:0]            reg_addr;
    logic                  wr_en, rd_en;
    logic                  unused_addr_bits;

    assign beat             = bus.din_valid & din_ready_q;
    assign reg_addr         = bus.cfg_paddr[5:2];
    assign wr_en            = bus.cfg_psel & ~bus.cfg_penable & bus.cfg_pwrite;
    assign rd_en            = bus.cfg_psel & ~bus.cfg_penable & ~bus.cfg_pwrite;
    assign unused_addr_bits = ^bus.cfg_paddr[1:0];

    // FSM: state register
    always_ff @(posedge clk or negedge rst_core_n_q) begin
        if (!rst_core_n_q) state_q <= ST_IDLE;
        else               state_q <= state_d;
    end

    // FSM: next state. In Check, Go=0 only takes effect at a frame end.
    always_comb begin
        state_d = state_q;
        if (clr_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (go_q) state_d = repeat_q ? ST_SYNC : ST_CHECK;
                ST_SYNC:  if (!go_q) state_d = ST_IDLE;
                          else if (beat && bus.din_eof) state_d = ST_CHECK;
                ST_CHECK: if (beat && bus.din_eof && !go_q) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs. The generators sit at their initial value whenever we
    // are not checking, so every entry into Check starts a fresh sequence.
    always_comb begin
        checking   = (state_q == ST_CHECK);
        check_beat = checking && beat && !clr_q;
        gen_init   = !checking || (check_beat && bus.din_eof && repeat_q);
    end

    lfsr17_shift #(.Seed(LfsrSeed)) u_lfsr (
        .clk   (clk),
        .rst   (!rst_core_n_q || clr_q),
        .init  (gen_init),
        .shift (check_beat),
        .state (lfsr_state)
    );

    always_comb begin
        case (pattern_q)
            2'd0:    exp_word = DataBits'(lfsr_state);
            2'd1:    exp_word = cnt_q;
            2'd2:    exp_word = '1;
            default: exp_word = '0;
        endcase
        mismatch = (bus.din_data != exp_word);
    end

`ifdef LFSR_CHECK_CAPTURE_EN
    // First mismatch since reset/Clr: sticky_q is still clear at that beat.
    logic [CountBits-1:0] cap_idx_q, cap_idx_d;
    logic [DataBits-1:0]  cap_exp_q, cap_exp_d, cap_rcv_q, cap_rcv_d;
    always_comb begin
        cap_idx_d = cap_idx_q;
        cap_exp_d = cap_exp_q;
        cap_rcv_d = cap_rcv_q;
        if (clr_q) begin
            cap_idx_d = '0;
            cap_exp_d = '0;
            cap_rcv_d = '0;
        end else if (check_beat && mismatch && !sticky_q) begin
            cap_idx_d = rx_count_q;
            cap_exp_d = exp_word;
            cap_rcv_d = bus.din_data;
        end
    end
    always_ff @(posedge clk or negedge rst_core_n_q) begin
        if (!rst_core_n_q) begin
            cap_idx_q <= '0;
            cap_exp_q <= '0;
            cap_rcv_q <= '0;
        end else begin
            cap_idx_q <= cap_idx_d;
            cap_exp_q <= cap_exp_d;
            cap_rcv_q <= cap_rcv_d;
        end
    end
`endif

    always_comb begin
        go_d            = go_q;
        clr_d           = clr_q;
        repeat_d        = repeat_q;
        length_d        = length_q;
        pattern_d       = pattern_q;
        rx_count_d      = rx_count_q;
        err_count_d     = err_count_q;
        frame_count_d   = frame_count_q;
        len_err_count_d = len_err_count_q;
        sticky_d        = sticky_q;
        word_idx_d      = word_idx_q;
        cnt_d           = cnt_q;
        prdata_d        = prdata_q;

        if (wr_en) begin
            case (reg_addr)
                4'd0:    go_d      = bus.cfg_pwdata[0];
                4'd2:    clr_d     = bus.cfg_pwdata[0];
                4'd3:    repeat_d  = bus.cfg_pwdata[0];
                4'd4:    length_d  = bus.cfg_pwdata;
                4'd5:    pattern_d = bus.cfg_pwdata[1:0];
                default: ;
            endcase
        end

        if (clr_q) begin
            rx_count_d      = '0;
            err_count_d     = '0;
            frame_count_d   = '0;
            len_err_count_d = '0;
            sticky_d        = 1'b0;
            word_idx_d      = '0;
            cnt_d           = '0;
        end else begin
            if (check_beat) begin
                rx_count_d = sat_inc(rx_count_q);
                if (mismatch) begin
                    err_count_d = sat_inc(err_count_q);
                    sticky_d    = 1'b1;
                end
                if (bus.din_eof) begin
                    frame_count_d = sat_inc(frame_count_q);
                    if (word_idx_q != length_q - 32'd1) begin
                        len_err_count_d = sat_inc(len_err_count_q);
                    end
                    word_idx_d = '0;
                end else begin
                    word_idx_d = word_idx_q + 32'd1;
                end
            end
            if (gen_init)        cnt_d = '0;
            else if (check_beat) cnt_d = cnt_q + DataBits'(1);
        end

        // Unmapped addresses leave the read register untouched.
        if (rd_en) begin
            case (reg_addr)
                4'd0:  prdata_d = 32'(go_q);
                4'd1:  prdata_d = 32'(rx_count_q);
                4'd2:  prdata_d = 32'(clr_q);
                4'd3:  prdata_d = 32'(repeat_q);
                4'd4:  prdata_d = length_q;
                4'd5:  prdata_d = 32'(pattern_q);
                4'd6:  prdata_d = 32'(err_count_q);
                4'd7:  prdata_d = 32'(frame_count_q);
                4'd8:  prdata_d = 32'(len_err_count_q);
                4'd9:  prdata_d = {30'd0, sticky_q, checking};
`ifdef LFSR_CHECK_CAPTURE_EN
                4'd10: prdata_d = 32'(cap_idx_q);
                4'd11: prdata_d = 32'(cap_exp_q);
                4'd12: prdata_d = 32'(cap_rcv_q);
`else
                4'd10, 4'd11, 4'd12: prdata_d = '0;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_core_n_q) begin
        if (!rst_core_n_q) begin
            go_q            <= GoDefault;
            clr_q           <= 1'b0;
            repeat_q        <= RepeatDefault;
            length_q        <= 32'(MaxLength);
            pattern_q       <= PatternDefault;
            rx_count_q      <= '0;
            err_count_q     <= '0;
            frame_count_q   <= '0;
            len_err_count_q <= '0;
            sticky_q        <= 1'b0;
            word_idx_q      <= '0;
            cnt_q           <= '0;
            prdata_q        <= '0;
        end else begin
            go_q            <= go_d;
            clr_q           <= clr_d;
            repeat_q        <= repeat_d;
            length_q        <= length_d;
            pattern_q       <= pattern_d;
            rx_count_q      <= rx_count_d;
            err_count_q     <= err_count_d;
            frame_count_q   <= frame_count_d;
            len_err_count_q <= len_err_count_d;
            sticky_q        <= sticky_d;
            word_idx_q      <= word_idx_d;
            cnt_q           <= cnt_d;
            prdata_q        <= prdata_d;
        end
    end

    assign bus.din_ready   = din_ready_q;
    assign bus.cfg_prdata  = prdata_q;
    assign bus.cfg_pready  = 1'b1;
    assign bus.cfg_pslverr = 1'b0;
endmodule

// File: tb/tb_lfsr_check.sv
// tb_lfsr_check -- directed bench for lfsr_check (DataBits=8, CountBits=4).
// Register reads push their expected value into exp_q when issued; a
// monitor pops and compares in the APB access phase.
module tb_lfsr_check;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_check_if #(.DataBits(8)) bus();

    lfsr_check #(.DataBits(8), .CountBits(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    localparam logic [3:0] A_GO = 4'd0, A_RX = 4'd1, A_CLR = 4'd2, A_REP = 4'd3;
    localparam logic [3:0] A_LEN = 4'd4, A_PAT = 4'd5, A_ERR = 4'd6, A_FRM = 4'd7;
    localparam logic [3:0] A_LERR = 4'd8, A_STAT = 4'd9, A_CIDX = 4'd10;
    localparam logic [3:0] A_CEXP = 4'd11, A_CRCV = 4'd12, A_NONE = 4'd13;

    // x^17+x^14+1 from seed 17'h15555, low byte, worked out by hand.
    logic [7:0] lfsr_tab [12] = '{8'h55, 8'hAB, 8'h57, 8'hAF, 8'h5F, 8'hBF,
                                  8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare read data during the access phase of each read.
    always @(negedge clk) begin
        if (rst_n && bus.cfg_psel && bus.cfg_penable && !bus.cfg_pwrite) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got %0h expected nothing", bus.cfg_prdata);
            end else begin
                check(name_q.pop_front(), bus.cfg_prdata, exp_q.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d);
        bus.cfg_psel    = 1'b1;
        bus.cfg_penable = 1'b0;
        bus.cfg_pwrite  = wr;
        bus.cfg_paddr   = {a, 2'b00};
        bus.cfg_pwdata  = d;
        wait_cyc(1);
        bus.cfg_penable = 1'b1;
        wait_cyc(1);
        bus.cfg_psel    = 1'b0;
        bus.cfg_penable = 1'b0;
        bus.cfg_pwrite  = 1'b0;
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
        apb(1'b1, a, d);
    endtask

    task automatic reg_rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        apb(1'b0, a, 32'd0);
    endtask

    task automatic send(input logic [7:0] d, input logic eof);
        int n;
        n = 0;
        bus.din_valid = 1'b1;
        bus.din_data  = d;
        bus.din_eof   = eof;
        while (!bus.din_ready && n < 50) begin
            wait_cyc(1);
            n++;
        end
        if (!bus.din_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: got ready=0 expected ready=1");
        end
        wait_cyc(1);
    endtask

    task automatic stop_stream();
        bus.din_valid = 1'b0;
        bus.din_eof   = 1'b0;
    endtask

    task automatic clear_all();
        reg_wr(A_GO, 32'd0);
        reg_wr(A_CLR, 32'd1);
        reg_rd(A_RX, 32'd0, "clr_rx_held");
        reg_wr(A_CLR, 32'd0);
    endtask

    logic [31:0] cap_idx, cap_exp, cap_rcv;

    initial begin
        bus.cfg_psel = 1'b0; bus.cfg_penable = 1'b0; bus.cfg_pwrite = 1'b0;
        bus.cfg_paddr = '0; bus.cfg_pwdata = '0;
        bus.din_valid = 1'b0; bus.din_data = '0; bus.din_eof = 1'b0;

        // Reset state
        #2;
        check("reset_ready", 32'(bus.din_ready), 32'd0);
        check("reset_prdata", bus.cfg_prdata, 32'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        #1;
        check("release_ready_before_edge", 32'(bus.din_ready), 32'd0);
        @(posedge clk); #1;
        check("release_ready_after_edge", 32'(bus.din_ready), 32'd1);
        check("pready", 32'(bus.cfg_pready), 32'd1);
        check("pslverr", 32'(bus.cfg_pslverr), 32'd0);
        wait_cyc(3);
        reg_rd(A_GO, 32'd0, "rst_go");
        reg_rd(A_LEN, 32'd1024, "rst_len");
        reg_rd(A_PAT, 32'd0, "rst_pat");
        reg_rd(A_REP, 32'd0, "rst_rep");
        reg_rd(A_STAT, 32'd0, "rst_status");
        reg_rd(A_CIDX, 32'd0, "rst_cap_idx");

        // Three clean LFSR frames, no repeat: LFSR runs on across frames
        reg_wr(A_LEN, 32'd4);
        reg_rd(A_LEN, 32'd4, "len_wr");
        reg_rd(A_NONE, 32'd4, "unmapped_keeps");
        reg_wr(A_GO, 32'd1);
        for (int i = 0; i < 12; i++) send(lfsr_tab[i], (i % 4) == 3);
        stop_stream();
        wait_cyc(2);
        reg_rd(A_RX, 32'd12, "lfsr_rx");
        reg_rd(A_FRM, 32'd3, "lfsr_frames");
        reg_rd(A_ERR, 32'd0, "lfsr_err");
        reg_rd(A_LERR, 32'd0, "lfsr_lenerr");
        reg_rd(A_STAT, 32'd1, "lfsr_status");
        clear_all();
        reg_rd(A_STAT, 32'd0, "after_clr_status");

        // Counter pattern with repeat; Go raised mid-frame
        reg_wr(A_PAT, 32'd1);
        reg_wr(A_REP, 32'd1);
        reg_wr(A_GO, 32'd1);
        send(8'd2, 1'b0);
        send(8'd3, 1'b1);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 4; i++) send(8'(i), i == 3);
        stop_stream();
        wait_cyc(2);
        reg_rd(A_RX, 32'd8, "sync_rx");
        reg_rd(A_ERR, 32'd0, "sync_err");
        reg_rd(A_FRM, 32'd2, "sync_frames");
        clear_all();

        // Zeros pattern, one bad word at index 5, then a second bad frame
        reg_wr(A_REP, 32'd0);
        reg_wr(A_PAT, 32'd3);
        reg_wr(A_LEN, 32'd8);
        reg_wr(A_GO, 32'd1);
        for (int i = 0; i < 8; i++) send((i == 5) ? 8'h01 : 8'h00, i == 7);
        stop_stream();
        wait_cyc(2);
`ifdef LFSR_CHECK_CAPTURE_EN
        cap_idx = 32'd5; cap_exp = 32'd0; cap_rcv = 32'h01;
`else
        cap_idx = 32'd0; cap_exp = 32'd0; cap_rcv = 32'd0;
`endif
        reg_rd(A_ERR, 32'd1, "zeros_err");
        reg_rd(A_STAT, 32'd3, "zeros_status");
        reg_rd(A_CIDX, cap_idx, "cap_idx");
        reg_rd(A_CRCV, cap_rcv, "cap_rcv");
        for (int i = 0; i < 8; i++) send((i == 1) ? 8'h80 : 8'h00, i == 7);
        stop_stream();
        wait_cyc(2);
        reg_rd(A_ERR, 32'd2, "zeros_err2");
        reg_rd(A_RX, 32'd15, "rx_saturated");
        reg_rd(A_CIDX, cap_idx, "cap_idx_kept");
        reg_rd(A_CEXP, cap_exp, "cap_exp_kept");
        reg_rd(A_CRCV, cap_rcv, "cap_rcv_kept");
        reg_rd(A_LERR, 32'd0, "zeros_lenerr");
        clear_all();

        // Short frame then a correct 4-word frame
        reg_wr(A_LEN, 32'd4);
        reg_wr(A_GO, 32'd1);
        for (int i = 0; i < 3; i++) send(8'h00, i == 2);
        for (int i = 0; i < 4; i++) send(8'h00, i == 3);
        stop_stream();
        wait_cyc(2);
        reg_rd(A_LERR, 32'd1, "short_lenerr");
        reg_rd(A_FRM, 32'd2, "short_frames");
        reg_rd(A_ERR, 32'd0, "short_err");
        reg_rd(A_RX, 32'd7, "short_rx");
        clear_all();

        // Ones pattern fed zeros: error count saturates, Clr clears it
        reg_wr(A_PAT, 32'd2);
        reg_wr(A_GO, 32'd1);
        for (int i = 0; i < 20; i++) send(8'h00, 1'b0);
        stop_stream();
        wait_cyc(2);
        reg_rd(A_ERR, 32'd15, "ones_err_sat");
        reg_rd(A_STAT, 32'd3, "ones_status");
        reg_wr(A_GO, 32'd0);
        reg_wr(A_CLR, 32'd1);
        reg_rd(A_ERR, 32'd0, "clr_err_held");
        reg_wr(A_CLR, 32'd0);
        reg_rd(A_STAT, 32'd0, "clr_status_idle");
        reg_rd(A_ERR, 32'd0, "clr_err");
        reg_rd(A_LERR, 32'd0, "clr_lenerr");
        reg_rd(A_PAT, 32'd2, "clr_keeps_pat");

        // Asynchronous reset in the middle of a frame
        reg_wr(A_PAT, 32'd3);
        reg_wr(A_GO, 32'd1);
        reg_rd(A_LEN, 32'd4, "pre_reset_len");
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        stop_stream();
        rst_n = 1'b0;
        #1;
        check("async_ready", 32'(bus.din_ready), 32'd0);
        check("async_prdata", bus.cfg_prdata, 32'd0);
        check("async_rx_count", 32'(dut.rx_count_q), 32'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(4);
        reg_rd(A_GO, 32'd0, "rst2_go");
        reg_rd(A_LEN, 32'd1024, "rst2_len");
        reg_rd(A_RX, 32'd0, "rst2_rx");
        reg_rd(A_STAT, 32'd0, "rst2_status");

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) wait_cyc(1);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL read_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
